// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 SRAM responder with independent write/read FSMs, one outstanding burst each.
// Define AXI_SRAM_WRAP_EN to support WRAP bursts; otherwise WRAP beats complete as INCR with SLVERR.
module axi_sram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_BITS    = 4,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_BITS-1:0]      s_AWID,
  input  logic [ADDR_WIDTH-1:0]   s_AWADDR,
  input  logic [LEN_BITS-1:0]     s_AWLEN,
  input  logic [SIZE_BITS-1:0]    s_AWSIZE,
  input  logic [1:0]              s_AWBURST,
  input  logic                    s_AWVALID,
  output logic                    s_AWREADY,
  input  logic [DATA_WIDTH-1:0]   s_WDATA,
  input  logic [DATA_WIDTH/8-1:0] s_WSTRB,
  input  logic                    s_WLAST,
  input  logic                    s_WVALID,
  output logic                    s_WREADY,
  output logic [ID_BITS-1:0]      s_BID,
  output logic [1:0]              s_BRESP,
  output logic                    s_BVALID,
  input  logic                    s_BREADY,
  input  logic [ID_BITS-1:0]      s_ARID,
  input  logic [ADDR_WIDTH-1:0]   s_ARADDR,
  input  logic [LEN_BITS-1:0]     s_ARLEN,
  input  logic [SIZE_BITS-1:0]    s_ARSIZE,
  input  logic [1:0]              s_ARBURST,
  input  logic                    s_ARVALID,
  output logic                    s_ARREADY,
  output logic [ID_BITS-1:0]      s_RID,
  output logic [DATA_WIDTH-1:0]   s_RDATA,
  output logic [1:0]              s_RRESP,
  output logic                    s_RLAST,
  output logic                    s_RVALID,
  input  logic                    s_RREADY
);
  localparam int OFF  = $clog2(DATA_WIDTH/8);
  localparam int SPAN = OFF + $clog2(MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [ADDR_WIDTH-1:0] mask, input logic [SIZE_BITS-1:0] size,
      input logic [1:0] burst, input logic wrap_ok);
    logic [ADDR_WIDTH-1:0] inc, res;
    inc = ADDR_WIDTH'(1) << size;
    if (burst == 2'b00) res = a;
    else if (burst == 2'b10 && wrap_ok) res = (a & ~mask) | ((a + inc) & mask);
    else res = a + inc;
    return res;
  endfunction

  function automatic logic beat_err(input logic [ADDR_WIDTH-SPAN-1:0] up,
      input logic [SIZE_BITS-1:0] size, input logic [1:0] burst, input logic wrap_ok);
    return (up != BASE_ADDR[ADDR_WIDTH-1:SPAN]) || (size > SIZE_BITS'(OFF)) ||
           (burst == 2'b11) || (burst == 2'b10 && !wrap_ok);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            w_state_q, w_state_d;
  logic [ID_BITS-1:0]    aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [LEN_BITS-1:0]   aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [SIZE_BITS-1:0]  aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic                  w_err_q, w_err_d;

  logic [1:0]            r_state_q, r_state_d;
  logic [ID_BITS-1:0]    ar_id_q, ar_id_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [LEN_BITS-1:0]   ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [SIZE_BITS-1:0]  ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  logic w_wrap_ok, r_wrap_ok, w_bad, r_bad, w_last_beat, w_we;
  logic [ADDR_WIDTH-1:0] w_mask, r_mask;

`ifdef AXI_SRAM_WRAP_EN
  assign w_wrap_ok = (aw_len_q == LEN_BITS'(1)) || (aw_len_q == LEN_BITS'(3)) ||
                     (aw_len_q == LEN_BITS'(7)) || (aw_len_q == LEN_BITS'(15));
  assign r_wrap_ok = (ar_len_q == LEN_BITS'(1)) || (ar_len_q == LEN_BITS'(3)) ||
                     (ar_len_q == LEN_BITS'(7)) || (ar_len_q == LEN_BITS'(15));
`else
  assign w_wrap_ok = 1'b0;
  assign r_wrap_ok = 1'b0;
`endif

  // Wrap boundary is (len+1)<<size bytes; the mask selects the offset within it.
  assign w_mask = ((ADDR_WIDTH'(aw_len_q) + ADDR_WIDTH'(1)) << aw_size_q) - ADDR_WIDTH'(1);
  assign r_mask = ((ADDR_WIDTH'(ar_len_q) + ADDR_WIDTH'(1)) << ar_size_q) - ADDR_WIDTH'(1);
  assign w_bad  = beat_err(aw_addr_q[ADDR_WIDTH-1:SPAN], aw_size_q, aw_burst_q, w_wrap_ok);
  assign r_bad  = beat_err(ar_addr_q[ADDR_WIDTH-1:SPAN], ar_size_q, ar_burst_q, r_wrap_ok);
  assign w_last_beat = (w_cnt_q == aw_len_q);
  assign w_we = (w_state_q == W_DATA) && s_WVALID && !w_bad;

  always_comb begin
    w_state_d = w_state_q;  aw_id_d = aw_id_q;      aw_addr_d = aw_addr_q;
    aw_len_d = aw_len_q;    aw_size_d = aw_size_q;  aw_burst_d = aw_burst_q;
    w_cnt_d = w_cnt_q;      w_err_d = w_err_q;
    case (w_state_q)
      W_IDLE: if (s_AWVALID) begin
        aw_id_d = s_AWID;     aw_addr_d = s_AWADDR;   aw_len_d = s_AWLEN;
        aw_size_d = s_AWSIZE; aw_burst_d = s_AWBURST;
        w_cnt_d = '0;         w_err_d = 1'b0;         w_state_d = W_DATA;
      end
      W_DATA: if (s_WVALID) begin
        // WLAST only flags a protocol error; the beat count ends the burst.
        w_err_d   = w_err_q | w_bad | (s_WLAST != w_last_beat);
        w_cnt_d   = w_cnt_q + LEN_BITS'(1);
        aw_addr_d = next_addr(aw_addr_q, w_mask, aw_size_q, aw_burst_q, w_wrap_ok);
        if (w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: if (s_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;  ar_id_d = ar_id_q;      ar_addr_d = ar_addr_q;
    ar_len_d = ar_len_q;    ar_size_d = ar_size_q;  ar_burst_d = ar_burst_q;
    r_cnt_d = r_cnt_q;      rdata_d = rdata_q;      rresp_d = rresp_q;
    rlast_d = rlast_q;
    case (r_state_q)
      R_IDLE: if (s_ARVALID) begin
        ar_id_d = s_ARID;     ar_addr_d = s_ARADDR;   ar_len_d = s_ARLEN;
        ar_size_d = s_ARSIZE; ar_burst_d = s_ARBURST;
        r_cnt_d = '0;         r_state_d = R_FETCH;
      end
      R_FETCH: begin
        rdata_d   = r_bad ? '0 : mem[ar_addr_q[SPAN-1:OFF]];
        rresp_d   = r_bad ? 2'b10 : 2'b00;
        rlast_d   = (r_cnt_q == ar_len_q);
        r_state_d = R_DATA;
      end
      R_DATA: if (s_RREADY) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          ar_addr_d = next_addr(ar_addr_q, r_mask, ar_size_q, ar_burst_q, r_wrap_ok);
          r_cnt_d   = r_cnt_q + LEN_BITS'(1);
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE; aw_id_q <= '0;   aw_addr_q <= '0; aw_len_q <= '0;
      aw_size_q <= '0;     aw_burst_q <= '0; w_cnt_q <= '0;  w_err_q <= 1'b0;
      r_state_q <= R_IDLE; ar_id_q <= '0;   ar_addr_q <= '0; ar_len_q <= '0;
      ar_size_q <= '0;     ar_burst_q <= '0; r_cnt_q <= '0;  rdata_q <= '0;
      rresp_q <= '0;       rlast_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d; aw_id_q <= aw_id_d;       aw_addr_q <= aw_addr_d;
      aw_len_q <= aw_len_d;   aw_size_q <= aw_size_d;   aw_burst_q <= aw_burst_d;
      w_cnt_q <= w_cnt_d;     w_err_q <= w_err_d;
      r_state_q <= r_state_d; ar_id_q <= ar_id_d;       ar_addr_q <= ar_addr_d;
      ar_len_q <= ar_len_d;   ar_size_q <= ar_size_d;   ar_burst_q <= ar_burst_d;
      r_cnt_q <= r_cnt_d;     rdata_q <= rdata_d;       rresp_q <= rresp_d;
      rlast_q <= rlast_d;
    end
  end

  // Array is never reset; a same-cycle fetch of a word being written sees the old value.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (s_WSTRB[b]) mem[aw_addr_q[SPAN-1:OFF]][8*b +: 8] <= s_WDATA[8*b +: 8];
      end
    end
  end

  assign s_AWREADY = (w_state_q == W_IDLE);
  assign s_WREADY  = (w_state_q == W_DATA);
  assign s_BVALID  = (w_state_q == W_RESP);
  assign s_BID     = aw_id_q;
  assign s_BRESP   = w_err_q ? 2'b10 : 2'b00;
  assign s_ARREADY = (r_state_q == R_IDLE);
  assign s_RVALID  = (r_state_q == R_DATA);
  assign s_RID     = ar_id_q;
  assign s_RDATA   = rdata_q;
  assign s_RRESP   = rresp_q;
  assign s_RLAST   = rlast_q;
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - scoreboard bench for axi_sram_slave (B/R expectations queued at drive time).
module tb_axi_sram_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [3:0] s_AWID, s_ARID, s_BID, s_RID, s_WSTRB;
  logic [31:0] s_AWADDR, s_ARADDR, s_WDATA, s_RDATA;
  logic [7:0] s_AWLEN, s_ARLEN;
  logic [2:0] s_AWSIZE, s_ARSIZE;
  logic [1:0] s_AWBURST, s_ARBURST, s_BRESP, s_RRESP;
  logic s_AWVALID, s_AWREADY, s_WLAST, s_WVALID, s_WREADY, s_BVALID, s_BREADY;
  logic s_ARVALID, s_ARREADY, s_RLAST, s_RVALID, s_RREADY;

  axi_sram_slave dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_AWID(s_AWID), .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
    .s_AWBURST(s_AWBURST), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST), .s_WVALID(s_WVALID),
    .s_WREADY(s_WREADY), .s_BID(s_BID), .s_BRESP(s_BRESP), .s_BVALID(s_BVALID),
    .s_BREADY(s_BREADY), .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN),
    .s_ARSIZE(s_ARSIZE), .s_ARBURST(s_ARBURST), .s_ARVALID(s_ARVALID),
    .s_ARREADY(s_ARREADY), .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .s_RLAST(s_RLAST), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;
  b_t bq[$];
  r_t rq[$];
  logic [31:0] model [1024];
  logic [31:0] wdat [16];
  int n_checks = 0, n_errors = 0, r_beats = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic wrap_ok(input logic [7:0] len);
`ifdef AXI_SRAM_WRAP_EN
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic bad_beat(input logic [31:0] a, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst);
    return (a >= 32'h1000) || (size > 3'd2) || (burst == 2'b11) ||
           (burst == 2'b10 && !wrap_ok(len));
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] inc, bound, base;
    inc = 32'd1 << size;
    bound = (32'(len) + 32'd1) * inc;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && wrap_ok(len)) begin
      base = a - (a % bound);
      return base + ((a - base + inc) % bound);
    end
    return a + inc;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_BVALID && s_BREADY) begin
        if (bq.size() == 0) check_eq("b_unexpected", 1, 0);
        else begin
          b_t e;
          e = bq.pop_front();
          check_eq("bid", s_BID, e.id);
          check_eq("bresp", s_BRESP, e.resp);
        end
      end
      if (s_RVALID && s_RREADY) begin
        r_beats++;
        if (rq.size() == 0) check_eq("r_unexpected", 1, 0);
        else begin
          r_t e;
          e = rq.pop_front();
          check_eq("rid", s_RID, e.id);
          check_eq("rdata", s_RDATA, e.data);
          check_eq("rresp", s_RRESP, e.resp);
          check_eq("rlast", s_RLAST, e.last);
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
      input int early, input int abort_after);
    logic [31:0] a;
    logic err, wl, bad;
    int to;
    a = addr; err = 1'b0;
    s_AWID = id; s_AWADDR = addr; s_AWLEN = len; s_AWSIZE = size; s_AWBURST = burst;
    s_AWVALID = 1'b1;
    to = 0;
    @(negedge clk);
    while (!s_AWREADY && to < 100) begin @(negedge clk); to++; end
    if (to >= 100) check_eq("aw_timeout", 1, 0);
    @(posedge clk); #1 s_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (abort_after >= 0 && i == abort_after) return;
      wl = (i == int'(len)) || (i == early);
      s_WDATA = wdat[i]; s_WSTRB = strb; s_WLAST = wl; s_WVALID = 1'b1;
      to = 0;
      @(negedge clk);
      while (!s_WREADY && to < 100) begin @(negedge clk); to++; end
      if (to >= 100) check_eq("w_timeout", 1, 0);
      @(posedge clk); #1 s_WVALID = 1'b0; s_WLAST = 1'b0;
      bad = bad_beat(a, len, size, burst);
      if (!bad)
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[(a >> 2) % 1024][8*b +: 8] = wdat[i][8*b +: 8];
      err = err | bad | (wl != (i == int'(len)));
      a = adv(a, len, size, burst);
    end
    bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic bad;
    int to;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      bad = bad_beat(a, len, size, burst);
      rq.push_back('{id: id, data: bad ? 32'h0 : model[(a >> 2) % 1024],
                     resp: bad ? 2'b10 : 2'b00, last: (i == int'(len))});
      a = adv(a, len, size, burst);
    end
    s_ARID = id; s_ARADDR = addr; s_ARLEN = len; s_ARSIZE = size; s_ARBURST = burst;
    s_ARVALID = 1'b1;
    to = 0;
    @(negedge clk);
    while (!s_ARREADY && to < 100) begin @(negedge clk); to++; end
    if (to >= 100) check_eq("ar_timeout", 1, 0);
    @(posedge clk); #1 s_ARVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int to;
    to = 0;
    while ((bq.size() != 0 || rq.size() != 0) && to < 300) begin @(negedge clk); to++; end
    if (to >= 300) check_eq("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] snap_d;
    logic snap_l;
    int base, to;
    rst_n = 1'b0;
    s_AWID = '0; s_AWADDR = '0; s_AWLEN = '0; s_AWSIZE = '0; s_AWBURST = '0; s_AWVALID = 1'b0;
    s_WDATA = '0; s_WSTRB = '0; s_WLAST = 1'b0; s_WVALID = 1'b0; s_BREADY = 1'b1;
    s_ARID = '0; s_ARADDR = '0; s_ARLEN = '0; s_ARSIZE = '0; s_ARBURST = '0; s_ARVALID = 1'b0;
    s_RREADY = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {s_AWREADY, s_ARREADY}, 2'b11);
    check_eq("rst_valids", {s_WREADY, s_BVALID, s_RVALID, s_RLAST}, 4'b0000);
    check_eq("rst_outs", {s_BID, s_BRESP, s_RID, s_RRESP, s_RDATA}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single write/read with RVALID latency
    wdat[0] = 32'hDEADBEEF;
    do_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 4'hF, -1, -1);
    wait_idle();
    do_read(4'd5, 32'h10, 8'd0, 3'd2, 2'b01);
    @(negedge clk); check_eq("rvalid_n1", s_RVALID, 1'b0);
    @(negedge clk); check_eq("rvalid_n2", s_RVALID, 1'b1);
    wait_idle();

    // INCR burst then byte-strobe overwrite
    wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3; wdat[3] = 32'd4;
    do_write(4'd1, 32'h0, 8'd3, 3'd2, 2'b01, 4'hF, -1, -1);
    wdat[0] = 32'hFF;
    do_write(4'd2, 32'h4, 8'd0, 3'd2, 2'b01, 4'h1, -1, -1);
    wait_idle();
    do_read(4'd6, 32'h0, 8'd3, 3'd2, 2'b01);
    wait_idle();

    // RREADY held low for 5 cycles after the first beat
    base = r_beats;
    do_read(4'd7, 32'h0, 8'd3, 3'd2, 2'b01);
    to = 0;
    while (r_beats < base + 1 && to < 50) begin @(negedge clk); to++; end
    @(posedge clk); #1 s_RREADY = 1'b0;
    to = 0;
    @(negedge clk);
    while (!s_RVALID && to < 50) begin @(negedge clk); to++; end
    if (to >= 50) check_eq("hold_timeout", 1, 0);
    snap_d = s_RDATA; snap_l = s_RLAST;
    repeat (5) begin
      @(negedge clk);
      check_eq("hold_stable", {s_RVALID, s_RLAST, s_RDATA}, {1'b1, snap_l, snap_d});
    end
    @(posedge clk); #1 s_RREADY = 1'b1;
    wait_idle();

    // BREADY low holds B and blocks AW
    s_BREADY = 1'b0;
    wdat[0] = 32'h12345678;
    do_write(4'd9, 32'h20, 8'd0, 3'd2, 2'b01, 4'hF, -1, -1);
    repeat (3) @(negedge clk);
    check_eq("b_hold", {s_BVALID, s_AWREADY}, 2'b10);
    @(posedge clk); #1 s_BREADY = 1'b1;
    wait_idle();

    // Early WLAST on beat 1
    wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
    do_write(4'd4, 32'h40, 8'd3, 3'd2, 2'b01, 4'hF, 1, -1);
    wait_idle();
    do_read(4'd4, 32'h40, 8'd3, 3'd2, 2'b01);
    wait_idle();

    // Out of range: word 0 alias must not change
    wdat[0] = 32'hBAD0BAD0;
    do_write(4'd8, 32'h1000, 8'd0, 3'd2, 2'b01, 4'hF, -1, -1);
    wait_idle();
    do_read(4'd8, 32'h0, 8'd0, 3'd2, 2'b01);
    do_read(4'd8, 32'h1000, 8'd0, 3'd2, 2'b01);
    wait_idle();

    // WRAP from 0x38 over a prefilled region
    wdat[0] = 32'h30; wdat[1] = 32'h34; wdat[2] = 32'h38; wdat[3] = 32'h3C;
    do_write(4'd1, 32'h30, 8'd3, 3'd2, 2'b01, 4'hF, -1, -1);
    wdat[0] = 32'hA0; wdat[1] = 32'hA1; wdat[2] = 32'hA2; wdat[3] = 32'hA3;
    do_write(4'd2, 32'h38, 8'd3, 3'd2, 2'b10, 4'hF, -1, -1);
    wait_idle();
    do_read(4'd3, 32'h38, 8'd3, 3'd2, 2'b10);
    wait_idle();
    do_read(4'd3, 32'h30, 8'd3, 3'd2, 2'b01);
    wait_idle();

    // Reset in W_DATA after 2 of 4 beats
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    do_write(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, -1, -1);
    wait_idle();
    wdat[0] = 32'h55; wdat[1] = 32'h66; wdat[2] = 32'h77; wdat[3] = 32'h88;
    do_write(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, -1, 2);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", {s_AWREADY, s_BVALID, s_WREADY}, 3'b100);
    @(posedge clk); #1 rst_n = 1'b1;
    do_read(4'd5, 32'h100, 8'd3, 3'd2, 2'b01);
    wait_idle();

    repeat (4) @(negedge clk);
    check_eq("bq_empty", bq.size(), 0);
    check_eq("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
